packet_header_inserter: RTL

Downstream stage of the packet analyzer. Pairs each entry of the packet-size stream with the matching packet-body stream, which arrives through a body FIFO. Emits one AXI-Stream packet per input packet, consisting of a single header beat carrying the byte count followed by the unmodified body beats. Also cross-checks the announced size against the actual body byte count, and keeps packet and error counters.

---
 rtl/packet_header_inserter_if.sv | 30 +++
 rtl/packet_header_inserter.sv | 104 ++++++++++
 2 files changed

// File: rtl/packet_header_inserter_if.sv
// packet_header_inserter_if: size, body and output AXI-Stream bundles for the header inserter
//   master: the environment side (drives the size/body streams, consumes axis_out)
//   slave : the inserter side (consumes the size/body streams, drives axis_out)
interface packet_header_inserter_if #(
  parameter int DW = 512
);
  logic [15:0]     axis_size_tdata;
  logic            axis_size_tvalid;
  logic            axis_size_tready;
  logic [DW-1:0]   axis_body_tdata;
  logic [DW/8-1:0] axis_body_tkeep;
  logic            axis_body_tlast;
  logic            axis_body_tvalid;
  logic            axis_body_tready;
  logic [DW-1:0]   axis_out_tdata;
  logic [DW/8-1:0] axis_out_tkeep;
  logic            axis_out_tlast;
  logic            axis_out_tvalid;
  logic            axis_out_tready;
  modport master (
    output axis_size_tdata, axis_size_tvalid, input axis_size_tready,
    output axis_body_tdata, axis_body_tkeep, axis_body_tlast, axis_body_tvalid, input axis_body_tready,
    input axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid, output axis_out_tready
  );
  modport slave (
    input axis_size_tdata, axis_size_tvalid, output axis_size_tready,
    input axis_body_tdata, axis_body_tkeep, axis_body_tlast, axis_body_tvalid, output axis_body_tready,
    output axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid, input axis_out_tready
  );
endinterface

// File: rtl/packet_header_inserter.sv
// packet_header_inserter: prepends a {HDR_MAGIC, size} header beat to each body packet and checks the size
//   clk, resetn  : clock, asynchronous active-low reset
//   bus          : size stream in, body stream in, axis_out stream out (single output register stage)
//   length_error : one-cycle pulse after a tlast whose byte total differs from the announced size
//   error_count  : saturating mismatch count
//   packet_count : wrapping count of completed packets
module packet_header_inserter #(
  parameter int          DW        = 512,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
  input  logic                   clk,
  input  logic                   resetn,
  packet_header_inserter_if.slave bus,
  output logic                   length_error,
  output logic [15:0]            error_count,
  output logic [31:0]            packet_count
);
  localparam int KW = DW / 8;
  typedef enum logic {IDLE, BODY} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [KW-1:0] tkeep_q, tkeep_d;
  logic          tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [15:0]   hdr_size_q, hdr_size_d, byte_acc_q, byte_acc_d, err_cnt_q, err_cnt_d;
  logic          len_err_q, len_err_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;
  logic          ld, size_hs, body_hs;
  logic [15:0]   total;
  // The output register may load whenever it is empty or being drained this cycle.
  assign ld = !tvalid_q | bus.axis_out_tready;
  assign bus.axis_size_tready = (state_q == IDLE) & ld;
  assign bus.axis_body_tready = (state_q == BODY) & ld;
  assign size_hs = bus.axis_size_tready & bus.axis_size_tvalid;
  assign body_hs = bus.axis_body_tready & bus.axis_body_tvalid;
  assign total = byte_acc_q + 16'($countones(bus.axis_body_tkeep));
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tvalid_d   = ld ? 1'b0 : tvalid_q;
    hdr_size_d = hdr_size_q;
    byte_acc_d = byte_acc_q;
    err_cnt_d  = err_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    len_err_d  = 1'b0;
    if (size_hs) begin
      tdata_d         = '0;
      tdata_d[31:0]   = {HDR_MAGIC, bus.axis_size_tdata};
      tkeep_d         = '0;
      tkeep_d[3:0]    = 4'hF;
      tlast_d         = 1'b0;
      tvalid_d        = 1'b1;
      hdr_size_d      = bus.axis_size_tdata;
      byte_acc_d      = '0;
      state_d         = BODY;
    end
    if (body_hs) begin
      tdata_d    = bus.axis_body_tdata;
      tkeep_d    = bus.axis_body_tkeep;
      tlast_d    = bus.axis_body_tlast;
      tvalid_d   = 1'b1;
      byte_acc_d = total;
      if (bus.axis_body_tlast) begin
        len_err_d = total != hdr_size_q;
        err_cnt_d = (len_err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        state_d   = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      hdr_size_q <= '0;
      byte_acc_q <= '0;
      err_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      hdr_size_q <= hdr_size_d;
      byte_acc_q <= byte_acc_d;
      err_cnt_q  <= err_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      len_err_q  <= len_err_d;
    end
  end
  assign bus.axis_out_tdata  = tdata_q;
  assign bus.axis_out_tkeep  = tkeep_q;
  assign bus.axis_out_tlast  = tlast_q;
  assign bus.axis_out_tvalid = tvalid_q;
  assign length_error        = len_err_q;
  assign error_count         = err_cnt_q;
  assign packet_count        = pkt_cnt_q;
endmodule
